// File: rtl/rf_write_arbiter_if.sv
// Write-request bus between the ALU/load requesters and the register-file write arbiter.
interface rf_write_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [XLEN-1:0]   req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [XLEN-1:0]   req1_data;
  logic              req1_ready;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              collide;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output flush,
    input  wr_en, wr_addr, wr_data, collide
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  flush,
    output wr_en, wr_addr, wr_data, collide
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with a registered write port.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin collision priority; otherwise requester 0 always wins.
module rf_write_arbiter #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
);

  logic              w_pri1;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_wr_en_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [XLEN-1:0]   w_wr_data_nxt;
  logic              w_collide_nxt;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]   r_wr_data;
  logic              r_collide;

  // Grant: flush blocks everything, a lone requester always wins, collisions follow priority.
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (bus.flush) begin
      w_ready0 = 1'b0;
      w_ready1 = 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      if (w_pri1) begin
        w_ready1 = 1'b1;
      end else begin
        w_ready0 = 1'b1;
      end
    end else begin
      w_ready0 = bus.req0_valid;
      w_ready1 = bus.req1_valid;
    end
  end

  assign w_xfer0 = bus.req0_valid && w_ready0;
  assign w_xfer1 = bus.req1_valid && w_ready1;

`ifdef RF_ARB_ROUND_ROBIN_EN
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  pri_e r_state;
  pri_e w_state_nxt;

  // Priority state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PRI0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The requester that just transferred loses the next collision; no transfer holds the state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PRI0: begin
        if (w_xfer0) begin
          w_state_nxt = PRI1;
        end else begin
          w_state_nxt = PRI0;
        end
      end
      PRI1: begin
        if (w_xfer1) begin
          w_state_nxt = PRI0;
        end else begin
          w_state_nxt = PRI1;
        end
      end
      default: w_state_nxt = PRI0;
    endcase
  end

  assign w_pri1 = (r_state == PRI1);
`else
  assign w_pri1 = 1'b0;
`endif

  // Next write-port contents: the winner's addr/data, enable suppressed for x0.
  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_collide_nxt = bus.req0_valid && bus.req1_valid && !bus.flush;
    if (w_xfer0) begin
      w_wr_en_nxt   = (bus.req0_addr != {ADDR_W{1'b0}});
      w_wr_addr_nxt = bus.req0_addr;
      w_wr_data_nxt = bus.req0_data;
    end else if (w_xfer1) begin
      w_wr_en_nxt   = (bus.req1_addr != {ADDR_W{1'b0}});
      w_wr_addr_nxt = bus.req1_addr;
      w_wr_data_nxt = bus.req1_data;
    end else begin
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
    end
  end

  // Registered write port and collision flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= {ADDR_W{1'b0}};
      r_wr_data <= {XLEN{1'b0}};
      r_collide <= 1'b0;
    end else begin
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_collide <= w_collide_nxt;
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.collide    = r_collide;

  rf_write_arbiter_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (bus.req0_valid),
    .req1_valid (bus.req1_valid),
    .req0_ready (w_ready0),
    .req1_ready (w_ready1),
    .flush      (bus.flush)
  );

endmodule

// Handshake invariants of the arbiter.
module rf_write_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic req0_valid,
  input logic req1_valid,
  input logic req0_ready,
  input logic req1_ready,
  input logic flush
);
  a_one_grant: assert property (@(posedge clk) disable iff (reset) !(req0_ready && req1_ready));
  a_ready0_needs_valid: assert property (@(posedge clk) disable iff (reset) req0_ready |-> req0_valid);
  a_ready1_needs_valid: assert property (@(posedge clk) disable iff (reset) req1_ready |-> req1_valid);
  a_flush_blocks: assert property (@(posedge clk) disable iff (reset) flush |-> !(req0_ready || req1_ready));
endmodule
